// File: rtl/cpu_pkg.sv
// Shared CPU constants: parameter defaults, the hardwired-zero register and
// the writeback trace format.
package cpu_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;
    localparam int BYPASS_DEF = 1;
    localparam int TRACE_DEF  = 1;

    localparam int ZERO_REG = 0;

    localparam string TRACE_FMT = "@%08h: $%02d <= %0h";
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register plus a running count
// of busy registers, updated incrementally.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_addr,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]        cnt
);
    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             set_hit, clr_hit, inc, dec;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        set_hit = set_en && (set_addr != ZERO_ADDR);
        clr_hit = clr_en && (clr_addr != ZERO_ADDR);
        // A same-address set wins, so the clear cannot count as a 1->0 transition.
        inc     = set_hit && !busy_q[set_addr];
        dec     = clr_hit && busy_q[clr_addr] && !(set_hit && (set_addr == clr_addr));
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        if (clr_hit) busy_d[clr_addr] = 1'b0;
        if (set_hit) busy_d[set_addr] = 1'b1;
        if (inc && !dec)      cnt_d = cnt_q + CNT_ONE;
        else if (dec && !inc) cnt_d = cnt_q - CNT_ONE;
        if (reset) begin
            busy_d = '0;
            cnt_d  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clk) begin
        busy_q <= busy_d;
        cnt_q  <= cnt_d;
    end

    assign busy = busy_q;
    assign cnt  = cnt_q;
endmodule

// File: rtl/pipe_reg_file.sv
// Pipelined register file: one write port, NRD combinational read ports with
// optional same-cycle forwarding, and a pending-writeback scoreboard.
module pipe_reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int BYPASS = BYPASS_DEF,
    parameter int TRACE  = TRACE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_dst,
    output logic [NRD-1:0]        pend,
    output logic [ADDR_W:0]       pend_cnt
);
    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok;

    assign wr_ok = we && (wa != ZERO_ADDR);

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[wa] = wd;
        // NOTE: the array is cleared on reset because reads must return zero
        // immediately afterwards; it is not left to power-up contents.
        if (reset) regs_d = '{default: '0};
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (iss_valid),
        .set_addr (iss_dst),
        .clr_en   (wr_ok),
        .clr_addr (wa),
        .busy     (busy),
        .cnt      (pend_cnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        logic              fwd;

        assign ra_k = ra[k*ADDR_W +: ADDR_W];
        assign fwd  = (BYPASS != 0) && we && (wa == ra_k);
        assign rd[k*DATA_W +: DATA_W] = (ra_k == ZERO_ADDR) ? '0 :
                                        fwd ? wd : regs_q[ra_k];
        // busy[0] is never set, so register 0 never reports pending.
        assign pend[k] = busy[ra_k] & ~fwd;
    end

    if (TRACE != 0) begin : g_trace
        always_ff @(posedge clk) begin
            if (!reset && wr_ok) $write("%s\n", $sformatf(TRACE_FMT, pc, wa, wd));
        end
    end else begin : g_no_trace
        logic unused_pc;
        assign unused_pc = ^pc;
    end
endmodule

// File: tb/tb_pipe_reg_file.sv
// Self-checking bench: a forwarding and a non-forwarding instance share all
// inputs and are compared against an array-based reference model.
module tb_pipe_reg_file;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [N*AW-1:0] ra;
    logic          iss_valid;
    logic [AW-1:0] iss_dst;

    logic [N*DW-1:0] rd_b, rd_n;
    logic [N-1:0]    pend_b, pend_n;
    logic [AW:0]     cnt_b, cnt_n;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] m_mem [32];
    bit            m_bit [32];

    always #5 clk = ~clk;

    pipe_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NRD(N), .BYPASS(1), .TRACE(1)) dut_b (
        .clk(clk), .reset(reset), .pc(pc), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .pend(pend_b), .pend_cnt(cnt_b)
    );

    pipe_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NRD(N), .BYPASS(0), .TRACE(0)) dut_n (
        .clk(clk), .reset(reset), .pc(pc), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_n),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .pend(pend_n), .pend_cnt(cnt_n)
    );

    // Reference model: architectural state after one clock edge.
    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = '0;
                m_bit[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) begin
                m_mem[wa] = wd;
                m_bit[wa] = 1'b0;
            end
            if (iss_valid && iss_dst != 0) m_bit[iss_dst] = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a, bit byp);
        if (a == 0) return '0;
        if (byp && we && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic bit exp_pend(logic [AW-1:0] a, bit byp);
        if (a == 0) return 1'b0;
        return m_bit[a] && !(byp && we && wa == a);
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_bit[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic iv, input logic [AW-1:0] dst);
        we = w; wa = a; wd = d; iss_valid = iv; iss_dst = dst;
        pc = $urandom;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        ra = {a2, a1, a0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1, 5'd9);
        set_ra(5'd0, 5'd0, 5'd0);
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        set_ra(5'd1, 5'd9, 5'd31);
        #1;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (rd_b[k*DW +: DW] !== '0) $display("FAIL reset_rd[%0d]: got %h expected 0", k, rd_b[k*DW +: DW]);
            else n_pass++;
        end
        n_checks++;
        if (pend_b !== '0 || pend_n !== '0) $display("FAIL reset_pend: got %b/%b expected 000", pend_b, pend_n);
        else n_pass++;
        n_checks++;
        if (cnt_b !== '0 || cnt_n !== '0) $display("FAIL reset_cnt: got %0d/%0d expected 0", cnt_b, cnt_n);
        else n_pass++;
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd3, 32'h1234, 1'b0, 5'd0);
        set_ra(5'd3, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (rd_b[0 +: DW] !== 32'h1234) $display("FAIL bypass_same_cycle: got %h expected 00001234", rd_b[0 +: DW]);
        else n_pass++;
        n_checks++;
        if (rd_n[0 +: DW] !== 32'h0) $display("FAIL nobypass_same_cycle: got %h expected 00000000", rd_n[0 +: DW]);
        else n_pass++;
        tick();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        #1;
        n_checks++;
        if (rd_b[0 +: DW] !== 32'h1234 || rd_n[0 +: DW] !== 32'h1234)
            $display("FAIL write_next_cycle: got %h/%h expected 00001234", rd_b[0 +: DW], rd_n[0 +: DW]);
        else n_pass++;
    endtask

    task automatic test_zero_write();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd12);
        tick();
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0);
        set_ra(5'd0, 5'd0, 5'd0);
        #1;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (rd_b[k*DW +: DW] !== '0) $display("FAIL zero_write_fwd[%0d]: got %h expected 0", k, rd_b[k*DW +: DW]);
            else n_pass++;
        end
        tick();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        #1;
        n_checks++;
        if (rd_b[0 +: DW] !== '0 || rd_n[0 +: DW] !== '0)
            $display("FAIL zero_write_read: got %h/%h expected 0", rd_b[0 +: DW], rd_n[0 +: DW]);
        else n_pass++;
        n_checks++;
        if (cnt_b !== 6'd1) $display("FAIL zero_write_cnt: got %0d expected 1", cnt_b);
        else n_pass++;
        drive(1'b1, 5'd12, 32'h0000_0C0C, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        #1;
        n_checks++;
        if (cnt_b !== 6'd0) $display("FAIL clear_12_cnt: got %0d expected 0", cnt_b);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd5); tick();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd7); tick();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd5); tick();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        set_ra(5'd5, 5'd7, 5'd0);
        #1;
        n_checks++;
        if (cnt_b !== 6'd2 || cnt_n !== 6'd2) $display("FAIL issue_cnt: got %0d/%0d expected 2", cnt_b, cnt_n);
        else n_pass++;
        n_checks++;
        if (pend_b !== 3'b011) $display("FAIL issue_pend: got %b expected 011", pend_b);
        else n_pass++;
        drive(1'b1, 5'd5, 32'h0000_5555, 1'b0, 5'd0);
        #1;
        n_checks++;
        if (pend_b[0] !== 1'b0 || pend_n[0] !== 1'b1)
            $display("FAIL write5_pend_fwd: got %b/%b expected 0/1", pend_b[0], pend_n[0]);
        else n_pass++;
        tick();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        #1;
        n_checks++;
        if (cnt_b !== 6'd1 || pend_b[0] !== 1'b0 || pend_n[0] !== 1'b0)
            $display("FAIL write5_clear: got cnt %0d pend %b/%b expected cnt 1 pend 0/0", cnt_b, pend_b[0], pend_n[0]);
        else n_pass++;
        drive(1'b1, 5'd9, 32'h0000_9999, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        set_ra(5'd9, 5'd7, 5'd0);
        #1;
        n_checks++;
        if (cnt_b !== 6'd1 || rd_b[0 +: DW] !== 32'h9999)
            $display("FAIL write9_nonpending: got cnt %0d rd %h expected cnt 1 rd 00009999", cnt_b, rd_b[0 +: DW]);
        else n_pass++;
    endtask

    task automatic test_issue_write_same();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd4); tick();
        drive(1'b1, 5'd4, 32'hAB, 1'b1, 5'd4); tick();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        set_ra(5'd4, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (pend_b[0] !== 1'b1 || cnt_b !== 6'd2)
            $display("FAIL set_priority: got pend %b cnt %0d expected pend 1 cnt 2", pend_b[0], cnt_b);
        else n_pass++;
        n_checks++;
        if (rd_b[0 +: DW] !== 32'hAB) $display("FAIL set_priority_data: got %h expected 000000ab", rd_b[0 +: DW]);
        else n_pass++;
    endtask

    task automatic test_fill_and_reset();
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, '0, 1'b1, AW'(i));
            tick();
        end
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        #1;
        n_checks++;
        if (cnt_b !== 6'd31 || cnt_n !== 6'd31) $display("FAIL fill_cnt: got %0d/%0d expected 31", cnt_b, cnt_n);
        else n_pass++;
        reset = 1'b1;
        drive(1'b1, 5'd10, 32'hCAFE_F00D, 1'b1, 5'd3);
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        set_ra(5'd3, 5'd4, 5'd10);
        #1;
        n_checks++;
        if (cnt_b !== '0 || cnt_n !== '0) $display("FAIL reset_over_ops_cnt: got %0d/%0d expected 0", cnt_b, cnt_n);
        else n_pass++;
        n_checks++;
        if (rd_b !== '0 || rd_n !== '0 || pend_b !== '0)
            $display("FAIL reset_over_ops_rd: got %h pend %b expected 0", rd_b, pend_b);
        else n_pass++;
    endtask

    task automatic test_multi_port();
        drive(1'b0, 5'd0, '0, 1'b1, 5'd6); tick();
        drive(1'b1, 5'd6, 32'h55, 1'b0, 5'd0);
        set_ra(5'd6, 5'd6, 5'd6);
        #1;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (rd_b[k*DW +: DW] !== 32'h55 || pend_b[k] !== 1'b0)
                $display("FAIL multi_fwd[%0d]: got rd %h pend %b expected 00000055/0", k, rd_b[k*DW +: DW], pend_b[k]);
            else n_pass++;
        end
        n_checks++;
        if (pend_n !== 3'b111) $display("FAIL multi_nofwd_pend: got %b expected 111", pend_n);
        else n_pass++;
        tick();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 200; c++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 1) == 1, AW'($urandom), $urandom,
                  $urandom_range(0, 2) != 0, AW'($urandom));
            for (int k = 0; k < N; k++)
                ra[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
            #1;
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (rd_b[k*DW +: DW] !== exp_rd(ra[k*AW +: AW], 1'b1) ||
                    rd_n[k*DW +: DW] !== exp_rd(ra[k*AW +: AW], 1'b0))
                    $display("FAIL rand_rd c%0d p%0d: got %h/%h expected %h/%h", c, k,
                             rd_b[k*DW +: DW], rd_n[k*DW +: DW],
                             exp_rd(ra[k*AW +: AW], 1'b1), exp_rd(ra[k*AW +: AW], 1'b0));
                else n_pass++;
                n_checks++;
                if (pend_b[k] !== exp_pend(ra[k*AW +: AW], 1'b1) ||
                    pend_n[k] !== exp_pend(ra[k*AW +: AW], 1'b0))
                    $display("FAIL rand_pend c%0d p%0d: got %b/%b expected %b/%b", c, k,
                             pend_b[k], pend_n[k], exp_pend(ra[k*AW +: AW], 1'b1), exp_pend(ra[k*AW +: AW], 1'b0));
                else n_pass++;
            end
            n_checks++;
            if (cnt_b !== 6'(exp_cnt()) || cnt_n !== 6'(exp_cnt()))
                $display("FAIL rand_cnt c%0d: got %0d/%0d expected %0d", c, cnt_b, cnt_n, exp_cnt());
            else n_pass++;
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
        ra = '0;
        test_reset();
        test_bypass();
        test_zero_write();
        test_scoreboard();
        test_issue_write_same();
        test_fill_and_reset();
        test_multi_port();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_reg_file.md
PIPE_REG_FILE -- requirements
Module: pipe_reg_file

Interface
REQ-001 SHALL take parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL take parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W.
REQ-003 SHALL take parameter NRD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL take parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding enabled.
REQ-005 SHALL take parameter TRACE, default 1, meaning 1 = print a simulation trace line per accepted write.
REQ-006 SHALL have port clk, input, 1, meaning the clock.
REQ-007 SHALL have port reset, input, 1, meaning reset: synchronous, active-high.
REQ-008 SHALL have port pc, input, 32, meaning PC of the writing instruction (trace only).
REQ-009 SHALL have ports we (input, 1), wa (input, ADDR_W) and wd (input, DATA_W), meaning write enable, write address and write data.
REQ-010 SHALL have port ra, input, NRD*ADDR_W, meaning packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rd, output, NRD*DATA_W, meaning packed read data, using the same packing as ra.
REQ-012 SHALL have ports iss_valid (input, 1) and iss_dst (input, ADDR_W), meaning an issued instruction will later write iss_dst.
REQ-013 SHALL have port pend, output, NRD, meaning pend[k] = the register at ra port k awaits writeback.
REQ-014 SHALL have port pend_cnt, output, ADDR_W+1, meaning the number of pending registers.

Function
REQ-015 SHALL treat address 0 as hardwired zero: reads return 0, writes to 0 are ignored, issues to 0 are ignored.
REQ-016 SHALL write wd into register wa at the rising clk edge when we=1 and wa!=0; the value is visible from the next cycle.
REQ-017 SHALL drive reads combinationally: rd_k = stored[ra_k].
REQ-018 SHALL, when BYPASS=1, drive rd_k = wd instead when we=1, wa=ra_k and ra_k!=0; all ports are independent, and several ports may forward at once.
REQ-019 SHALL, when TRACE=1, print "@<pc hex 8>: $<wa dec 2> <= <wd hex>" exactly once per accepted write; nothing is printed for wa=0 or during reset.
REQ-020 SHALL keep a pending bit per register: set at the edge with iss_valid=1 (iss_dst!=0); cleared at the edge with an accepted write to that address.
REQ-021 SHALL give set priority when issue and write target the same address in one cycle: the bit ends set and the data is still written.
REQ-022 SHALL leave the bit and the count unchanged on an issue to an already-pending register.
REQ-023 SHALL leave the bit and the count unchanged on a write to a non-pending register; the data is written.
REQ-024 SHALL drive pend[k] = bit[ra_k] & ~(BYPASS & we & wa==ra_k); pend[k] is always 0 for ra_k=0.
REQ-025 SHALL update pend_cnt incrementally as a registered output: +1 per 0->1 transition, -1 per 1->0 transition, net 0 when both occur in one cycle; range 0..2**ADDR_W-1, never wrapping.

Reset
REQ-026 SHALL, at the edge with reset=1, clear all registers, all pending bits and pend_cnt to 0; reset overrides we and iss_valid in the same cycle.
REQ-027 SHALL present rd=0, pend=0 and pend_cnt=0 in the cycle after reset, for any ra; no output may depend on initial blocks.

Structure
REQ-028 SHALL take default parameter values, the ZERO_REG address constant and the trace format string from shared package cpu_pkg.
REQ-029 SHALL implement the pending bits and pend_cnt in one sub-module, reg_scoreboard (inputs: set/clear strobes and addresses; outputs: bit vector and count).
REQ-030 SHALL not instantiate any further sub-modules and SHALL keep storage as a flat register array.

Verification
REQ-031 SHALL cover: we=1, wa=3, wd=0x1234 with ra0=3 in the same cycle -> rd0=0x1234 (BYPASS=1), rd0=0 (BYPASS=0); next cycle rd0=0x1234 in both cases.
REQ-032 SHALL cover: we=1, wa=0, wd=0xFFFFFFFF -> rd for ra=0 stays 0; no trace line; pend_cnt unchanged.
REQ-033 SHALL cover: issue 5, issue 7, issue 5 -> pend_cnt=2; write 5 -> pend_cnt=1 and pend for ra=5 = 0; write 9 -> pend_cnt=1.
REQ-034 SHALL cover: issue 4 and write 4 (0xAB) in one cycle with 4 pending -> bit stays 1, pend_cnt unchanged, stored[4]=0xAB.
REQ-035 SHALL cover: issue all 31 nonzero registers -> pend_cnt=31; reset with we=1 and iss_valid=1 -> pend_cnt=0, all rd=0 next cycle.
REQ-036 SHALL cover: NRD=3, all three ports read the same address 6 during a write of 0x55 -> all rd=0x55 and all pend=0.
